// File: rtl/freq_div_pkg.sv
// Shared types and constants for the round-robin frequency-divider scheduler.
package freq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr (mod NREQ), one-hot out.
module rr_arbiter #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            if (!found && req[IW'((32'(ptr) + i) % NREQ)]) begin
                gnt[IW'((32'(ptr) + i) % NREQ)] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/freq_div_sched.sv
// Grants one requester at a time a BURST-period divided clock on Q at its own ratio.
// Optional early release on request drop: define FREQ_DIV_SCHED_ABORT_EN.
module freq_div_sched
    import freq_div_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] div,
    output logic [NREQ-1:0]    gnt,
    output logic               busy,
    output logic               done,
    output logic               Q
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned BW = (BURST > 1) ? $clog2(BURST) : 1;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              q_q, q_d;
    logic [DW-1:0]     n_q, n_d;
    logic [DW-1:0]     k_q, k_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     idx_q, idx_d;

    logic [NREQ-1:0]   arb_gnt;
    logic [IW-1:0]     arb_idx;
    logic [DW-1:0]     div_sel;
    logic              last_k;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (arb_gnt)
    );

    // One-hot winner to index, and the winner's divide ratio.
    always_comb begin
        arb_idx = '0;
        div_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) arb_idx = IW'(i);
            if (idx_q == IW'(i)) div_sel = div[i*DW +: DW];
        end
    end

    assign last_k = (k_q == n_q - DW'(1));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        n_d     = n_q;
        k_d     = k_q;
        burst_d = burst_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = LOAD;
                    gnt_d   = arb_gnt;
                    idx_d   = arb_idx;
                end
            end
            LOAD: begin
                n_d     = (div_sel < DW'(MIN_DIV)) ? DW'(MIN_DIV) : div_sel;
                k_d     = '0;
                burst_d = '0;
                state_d = RUN;
            end
            RUN: begin
                if (last_k) begin
                    k_d     = '0;
                    burst_d = burst_q + BW'(1);
                    if (burst_q == BW'(BURST - 1)) state_d = DONE;
`ifdef FREQ_DIV_SCHED_ABORT_EN
                    if (!req[idx_q]) state_d = DONE;
`endif
                end else begin
                    k_d = k_q + DW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                ptr_d   = idx_q;
            end
            default: state_d = IDLE;
        endcase

        // Outputs follow the next state so they line up with the state register.
        q_d    = (state_d == RUN) && (k_d < (n_d >> 1));
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= 1'b0;
            n_q     <= '0;
            k_q     <= '0;
            burst_q <= '0;
            ptr_q   <= IW'(NREQ - 1);
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            q_q     <= q_d;
            n_q     <= n_d;
            k_q     <= k_d;
            burst_q <= burst_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    assign gnt  = gnt_q;
    assign busy = busy_q;
    assign done = done_q;
    assign Q    = q_q;

endmodule

// File: tb/tb_freq_div_sched.sv
// Scoreboard bench for freq_div_sched: grant timelines are predicted per episode and checked each cycle.
module tb_freq_div_sched;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic            busy;
        logic            done;
        logic            q;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] div;
    logic [NREQ-1:0]    gnt;
    logic               busy;
    logic               done;
    logic               Q;

    logic [DW-1:0] divs [NREQ];
    exp_t          exp_q [$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    int            cycle = 0;
    int            done_seen = 0;
    int            done_exp = 0;
    int            last = NREQ - 1;

    freq_div_sched #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .div  (div),
        .gnt  (gnt),
        .busy (busy),
        .done (done),
        .Q    (Q)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_div();
        for (int i = 0; i < NREQ; i++) div[i*DW +: DW] = divs[i];
    endtask

    function automatic void push(input logic [NREQ-1:0] g, input logic b, input logic d, input logic q);
        exp_q.push_back(exp_t'({g, b, d, q}));
    endfunction

    function automatic int clamp(input logic [DW-1:0] d);
        return (d < 2) ? 2 : int'(d);
    endfunction

    function automatic int pick(input logic [NREQ-1:0] rq);
        for (int i = 1; i <= NREQ; i++)
            if (rq[(last + i) % NREQ]) return (last + i) % NREQ;
        return 0;
    endfunction

    // One arbitration from an IDLE cycle through DONE; c indices count RUN cycles from 0.
    task automatic episode(input logic [NREQ-1:0] rq, input int drop_at, input int chg_at,
                           input logic [DW-1:0] chg_val, input int noise_at, input int rst_at);
        int w, n, periods;
        logic [NREQ-1:0] oh;
        req = rq;
        push('0, 1'b0, 1'b0, 1'b0);
        step();
        if (rq == '0) return;
        w  = pick(rq);
        oh = NREQ'(1) << w;
        push(oh, 1'b1, 1'b0, 1'b0);
        n = clamp(divs[w]);
        step();
        periods = BURST;
`ifdef FREQ_DIV_SCHED_ABORT_EN
        if (drop_at >= 0 && drop_at / n + 1 < BURST) periods = drop_at / n + 1;
`endif
        for (int c = 0; c < periods * n; c++) begin
            if (c == drop_at) req[w] = 1'b0;
            if (c == noise_at) req = req | (NREQ'($urandom) & ~oh);
            if (c == chg_at) begin
                divs[w] = chg_val;
                drive_div();
            end
            push(oh, 1'b1, 1'b0, (c % n) < (n / 2));
            if (c == rst_at) begin
                rst = 1'b1;
                step();
                rst  = 1'b0;
                last = NREQ - 1;
                return;
            end
            step();
        end
        push(oh, 1'b1, 1'b1, 1'b0);
        done_exp++;
        last = w;
        step();
    endtask

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    always @(negedge clk) begin
        cycle <= cycle + 1;
        if (done === 1'b1) done_seen <= done_seen + 1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks = checks + 1;
            if (gnt !== mon_e.gnt || busy !== mon_e.busy || done !== mon_e.done || Q !== mon_e.q) begin
                errors = errors + 1;
                $display("FAIL cycle %0d: gnt/busy/done/Q got %b/%b/%b/%b expected %b/%b/%b/%b",
                         cycle, gnt, busy, done, Q, mon_e.gnt, mon_e.busy, mon_e.done, mon_e.q);
            end
        end
    end

    initial begin
        rst = 1'b1;
        req = '0;
        for (int i = 0; i < NREQ; i++) divs[i] = '0;
        drive_div();
        step();
        push('0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;

        // All requesting at ratio 2: rotation 0,1,2,3,0.
        for (int i = 0; i < NREQ; i++) divs[i] = DW'(2);
        drive_div();
        for (int e = 0; e < 5; e++) episode(4'hF, -1, -1, '0, -1, -1);
        episode(4'h0, -1, -1, '0, -1, -1);

        // Single requester, ratio 4, then odd and clamped ratios.
        divs[0] = DW'(4); drive_div();
        episode(4'h1, -1, -1, '0, -1, -1);
        divs[0] = DW'(5); drive_div();
        episode(4'h1, -1, -1, '0, -1, -1);
        divs[0] = DW'(0); drive_div();
        episode(4'h1, -1, -1, '0, -1, -1);
        divs[0] = DW'(1); drive_div();
        episode(4'h1, -1, -1, '0, -1, -1);

        // Ratio changed mid-run has no effect; request dropped at RUN cycle 5.
        divs[0] = DW'(4); drive_div();
        episode(4'h1, -1, 3, DW'(6), -1, -1);
        divs[0] = DW'(4); drive_div();
        episode(4'h1, 5, -1, '0, -1, -1);
        episode(4'h0, -1, -1, '0, -1, -1);

        // Reset at RUN cycle 6 with pointer at 0; next grant must still be requester 0.
        episode(4'h1, -1, -1, '0, -1, -1);
        episode(4'h1, -1, -1, '0, -1, 6);
        episode(4'hF, -1, -1, '0, -1, -1);

        for (int e = 0; e < 30; e++) begin
            int drop, noise;
            for (int i = 0; i < NREQ; i++) divs[i] = DW'($urandom_range(0, 9));
            drive_div();
            drop  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20)) : -1;
            noise = int'($urandom_range(0, 12));
            episode(NREQ'($urandom_range(0, 15)), drop, -1, '0, noise, -1);
        end

        req = '0;
        push('0, 1'b0, 1'b0, 1'b0);
        step();
        push('0, 1'b0, 1'b0, 1'b0);
        step();
        @(negedge clk);
        #1;

        checks++;
        if (done_seen != done_exp) begin
            errors++;
            $display("FAIL done_count: got %0d expected %0d", done_seen, done_exp);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/freq_div_sched.md
FREQ_DIV_SCHED -- requirements
Module: freq_div_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters.
REQ-002 SHALL have parameter DW, default 8: divide-ratio width.
REQ-003 SHALL have parameter BURST, default 4: output periods per grant.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have port req, input, NREQ: per-requester level request.
REQ-007 SHALL have port div, input, NREQ*DW: divide ratio of requester i in bits [i*DW +: DW].
REQ-008 SHALL have port gnt, output, NREQ: one-hot grant, zero when idle.
REQ-009 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-010 SHALL have port done, output, 1: one-cycle pulse at the end of each grant.
REQ-011 SHALL have port Q, output, 1: divided-clock output, registered.

Function
REQ-012 SHALL implement the FSM IDLE -> LOAD -> RUN -> DONE -> IDLE.
REQ-013 In IDLE with any req bit high, SHALL pick the winner round-robin, searching from (last granted index + 1) mod NREQ, and enter LOAD with gnt set to that one-hot bit on the next edge.
REQ-014 LOAD SHALL last exactly 1 cycle: latch div of the winner as ratio N, clamp N<2 to N=2, clear the period counter k and the burst counter, and hold Q=0.
REQ-015 RUN SHALL count k = 0..N-1 and then wrap to 0; each wrap increments the burst counter.
REQ-016 In RUN, Q SHALL be 1 for k < floor(N/2) and 0 otherwise; the period is exactly N clk cycles.
REQ-017 An odd N SHALL give a high phase of floor(N/2) cycles and a low phase of ceil(N/2) cycles.
REQ-018 When k = N-1 and the burst counter = BURST-1, SHALL enter DONE on the next edge.
REQ-019 DONE SHALL last 1 cycle with done=1, Q=0 and gnt still asserted, then return to IDLE with gnt=0 and the pointer updated to the granted index.
REQ-020 Latency from req rising in IDLE at cycle t: gnt at t+1, first Q=1 at t+2 (for N>=2).
REQ-021 Back-to-back grants SHALL spend at least one IDLE cycle between DONE and the next LOAD.
REQ-022 div and req changes during LOAD/RUN/DONE SHALL NOT alter the latched N.
REQ-023 Requests from other requesters arriving during a grant SHALL be held off until the next IDLE arbitration.
REQ-024 Q SHALL be 0 in IDLE, LOAD and DONE.

Reset
REQ-025 rst=1 SHALL force IDLE, gnt=0, busy=0, done=0, Q=0, counters=0, and the round-robin pointer to NREQ-1 (so requester 0 has first priority).
REQ-026 rst asserted mid-RUN SHALL abort immediately, with no done pulse.

Configuration
REQ-027 The macro FREQ_DIV_SCHED_ABORT_EN SHALL control early release.
REQ-028 With FREQ_DIV_SCHED_ABORT_EN defined: if req of the granted requester is low at k = N-1 in RUN, SHALL enter DONE on the next edge regardless of the burst count.
REQ-029 Without FREQ_DIV_SCHED_ABORT_EN: req SHALL be ignored after grant and every grant SHALL run the full BURST periods.

Structure
REQ-030 A shared package freq_div_pkg SHALL hold the FSM state enum (IDLE, LOAD, RUN, DONE) and the constant MIN_DIV=2.
REQ-031 The round-robin arbiter SHALL be the sub-module rr_arbiter (NREQ-wide, with inputs req and pointer, output one-hot grant).
REQ-032 The divide counter and Q generation SHALL remain in freq_div_sched.

Verification
REQ-033 Reset then req=4'b0001, div0=4: gnt=0001 one cycle after req; Q pattern 1100 repeated 4 times (16 cycles); done pulse; gnt=0 after it.
REQ-034 req=4'b1111 held, all div=2: grants in order 0001, 0010, 0100, 1000, 0001; each grant gives 4 periods of 10 and one done pulse.
REQ-035 div0=5: Q per period is 11000 (2 high, 3 low); div0=0 and div0=1: behaves as N=2, Q=10.
REQ-036 rst pulsed at RUN cycle 6 with div0=4: next cycle gnt=0, Q=0, busy=0, done=0; next grant goes to requester 0.
REQ-037 With FREQ_DIV_SCHED_ABORT_EN, div0=4, req0 dropped at RUN cycle 5: DONE after cycle 7 (2 periods total); without the macro: the full 4 periods.
REQ-038 div0 changed from 4 to 6 during RUN: period stays 4 until done.
